gate_response_checker: RTL and testbench
========================================

# gate_response_checker

Synthesizable response checker for the basic gate models. It receives stimulus/response vectors {a, b, c} over a valid/ready handshake and compares c against the expected output of a selected 2-input gate function. It counts vectors and mismatches, latches the first failing vector, and reports pass/fail at the end of a programmed run. It sits on the receive side of the gate stimulus generators and replaces waveform inspection with a hardware verdict.

## Interface
- CNT_W, 8, width of vector count, fail count and index outputs
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low
- start  input  1  one-cycle request to begin a run; func and num_vec are sampled on the same edge
- func  input  3  expected function: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 BUF a
- num_vec  input  CNT_W  number of vectors in the run
- in_valid  input  1  vector present on a, b, c
- in_ready  output  1  checker accepts a vector this cycle
- a, b  input  1 each  stimulus applied to the DUT
- c  input  1  DUT output for (a, b)
- busy  output  1  run in progress
- done  output  1  run complete; held until the next accepted start
- pass  output  1  qualified by done; 1 iff fail_cnt == 0
- vec_cnt  output  CNT_W  vectors accepted in the current run
- fail_cnt  output  CNT_W  mismatches; saturates at all-ones
- first_fail_valid  output  1  at least one mismatch recorded
- first_fail_idx  output  CNT_W  vec_cnt value at the first mismatch (0-based)
- first_fail_vec  output  3  {a, b, c} of the first mismatch

## Operation
- States:
  - IDLE: reset state.
  - RUN: busy=1, in_ready=1.
  - DONE: done=1.
- start in IDLE or DONE:
  - Latches func and num_vec.
  - Clears vec_cnt, fail_cnt, first_fail_*.
  - Goes to RUN, or to DONE directly if num_vec == 0 (pass=1).
- start in RUN is ignored.
- Accept occurs when in_valid && in_ready.
- On accept:
  - exp is computed from latched func, a and b.
  - On mismatch (c != exp), fail_cnt increments with saturation.
  - If first_fail_valid == 0 on a mismatch: record first_fail_idx = vec_cnt (pre-increment) and first_fail_vec = {a, b, c}, and set first_fail_valid.
  - vec_cnt increments.
- An accept with vec_cnt + 1 == num_vec moves the FSM to DONE.
- After DONE, in_valid is ignored (in_ready=0).
- Reset values: state IDLE. in_ready, busy, done, pass, first_fail_valid are 0. All counters and first_fail_* are 0.
- pass is 0 whenever done is 0.

## Timing
- All outputs are registered except in_ready, which is decoded from the state register.
- Compare-to-update latency is 1 cycle: counters and first_fail_* reflect an accept at edge N after edge N.
- Throughput is one vector per cycle; in_valid may stay high back-to-back.
- done and pass rise one edge after the final accept.
- busy and in_ready fall on that same edge.
- start and the final accept cannot coincide, because start is ignored in RUN.
- start in DONE: done and pass drop and busy rises on the next edge. Counters clear on that edge.
- Reset asserted mid-run: immediately returns to IDLE and all outputs go to reset values. The partial run is lost.
- fail_cnt saturation: it holds at 2^CNT_W−1 while vec_cnt keeps counting.
- num_vec max is 2^CNT_W−1, so vec_cnt never wraps.

## Structure
- Package gate_chk_pkg:
  - state enum {IDLE, RUN, DONE}
  - func encoding localparams (FN_NAND … FN_BUF)
  - default CNT_W
- Sub-module gate_ref_eval: purely combinational (func, a, b) → exp.
  - Reused by later checkers and the generator's self-test.
- Top module holds the FSM, counters and capture registers.

## Test plan
- All NAND vectors correct: func=0, num_vec=4; vectors (0,0,1), (0,1,1), (1,0,1), (1,1,0) back-to-back. Expect done one edge after the 4th accept, pass=1, vec_cnt=4, fail_cnt=0, first_fail_valid=0.
- Single error: func=0, num_vec=4; 3rd vector (1,0,0). Expect fail_cnt=1, first_fail_idx=2, first_fail_vec=3'b100, pass=0.
- Gaps and ignored inputs: func=4 (XOR), num_vec=3, in_valid toggled with idle gaps. Expect only accepted vectors counted. A start pulse mid-run has no effect. in_valid after DONE is ignored and vec_cnt stays 3.
- Zero-length and restart: num_vec=0 gives done=1, pass=1 one edge after start. A new start with func=6, num_vec=2 clears outputs and runs.
- Saturation: CNT_W=3, num_vec=7, every vector wrong. Expect fail_cnt=7 and first_fail_idx=0.
- Reset mid-run: assert rst_n=0 after 2 of 4 vectors. Expect every output at 0 immediately without waiting for clk, and IDLE after release.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker family.
//   CNT_W_DEFAULT : default width of the vector/fail counters and index outputs
//   FN_*          : encoding of the expected 2-input gate function
//   state_e       : checker FSM states
package gate_chk_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  localparam logic [2:0] FN_NAND = 3'd0;
  localparam logic [2:0] FN_AND  = 3'd1;
  localparam logic [2:0] FN_OR   = 3'd2;
  localparam logic [2:0] FN_NOR  = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;
  localparam logic [2:0] FN_XNOR = 3'd5;
  localparam logic [2:0] FN_NOT  = 3'd6;
  localparam logic [2:0] FN_BUF  = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/gate_response_checker_if.sv
// Vector handshake between a gate stimulus source and the response checker.
//   in_valid : source has a vector on a, b, c
//   in_ready : checker accepts the vector this cycle
//   a, b     : stimulus applied to the gate under test
//   c        : gate output observed for (a, b)
// master = vector source, slave = checker.
interface gate_response_checker_if;
  logic in_valid;
  logic in_ready;
  logic a;
  logic b;
  logic c;

  modport master (
    output in_valid,
    output a,
    output b,
    output c,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  c,
    output in_ready
  );
endinterface

// File: rtl/gate_ref_eval.sv
// Reference model of the basic 2-input gates, purely combinational.
//   func : selected function (FN_* encoding)
//   a, b : gate inputs
//   exp  : expected gate output
module gate_ref_eval
  import gate_chk_pkg::*;
(
  input  logic [2:0] func,
  input  logic       a,
  input  logic       b,
  output logic       exp
);

  always_comb begin
    exp = 1'b0;
    unique case (func)
      FN_NAND: exp = ~(a & b);
      FN_AND:  exp = a & b;
      FN_OR:   exp = a | b;
      FN_NOR:  exp = ~(a | b);
      FN_XOR:  exp = a ^ b;
      FN_XNOR: exp = ~(a ^ b);
      FN_NOT:  exp = ~a;
      FN_BUF:  exp = a;
      default: exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_response_checker.sv
// Hardware verdict for a run of gate stimulus/response vectors.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a run (ignored while busy); samples func and num_vec
//   func, num_vec    : expected gate function and run length
//   vec              : vector handshake (slave side)
//   busy, done, pass : run status; pass is qualified by done
//   vec_cnt          : vectors accepted in the current run
//   fail_cnt         : mismatches, saturating at all-ones
//   first_fail_*     : valid flag, vec_cnt index and {a, b, c} of the first mismatch
module gate_response_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            func,
  input  logic [CNT_W-1:0]      num_vec,
  gate_response_checker_if.slave vec,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_W-1:0]      vec_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic                  first_fail_valid,
  output logic [CNT_W-1:0]      first_fail_idx,
  output logic [2:0]            first_fail_vec
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q;
  logic [2:0]       func_q;
  logic [CNT_W-1:0] num_vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [CNT_W-1:0] vec_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic             ff_valid_q;
  logic [CNT_W-1:0] ff_idx_q;
  logic [2:0]       ff_vec_q;

  logic             exp;
  logic             accept;
  logic             mismatch;
  logic [CNT_W-1:0] vec_cnt_inc;

  gate_ref_eval u_ref_eval (
    .func (func_q),
    .a    (vec.a),
    .b    (vec.b),
    .exp  (exp)
  );

  assign vec.in_ready = (state_q == StRun);
  assign accept       = vec.in_valid & vec.in_ready;
  assign mismatch     = (vec.c != exp);
  assign vec_cnt_inc  = vec_cnt_q + CntOne;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      func_q     <= '0;
      num_vec_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      vec_cnt_q  <= '0;
      fail_cnt_q <= '0;
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      ff_vec_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            func_q     <= func;
            num_vec_q  <= num_vec;
            vec_cnt_q  <= '0;
            fail_cnt_q <= '0;
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_vec_q   <= '0;
            if (num_vec == '0) begin
              // Empty run completes immediately with a clean verdict.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end
        StRun: begin
          if (accept) begin
            vec_cnt_q <= vec_cnt_inc;
            if (mismatch) begin
              if (fail_cnt_q != CntMax) begin
                fail_cnt_q <= fail_cnt_q + CntOne;
              end
              if (!ff_valid_q) begin
                ff_valid_q <= 1'b1;
                ff_idx_q   <= vec_cnt_q;
                ff_vec_q   <= {vec.a, vec.b, vec.c};
              end
            end
            if (vec_cnt_inc == num_vec_q) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              // Fold in the final vector, whose mismatch is not yet in fail_cnt_q.
              pass_q  <= (fail_cnt_q == '0) && !mismatch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign vec_cnt          = vec_cnt_q;
  assign fail_cnt         = fail_cnt_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
  assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_gate_response_checker.sv
module tb_gate_response_checker;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] vc;
    logic [7:0] fc;
    logic       ffv;
    logic [7:0] idx;
    logic [2:0] fvec;
  } snap_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] func;
  logic [7:0] num_vec;
  logic       busy, done, pass, ffv;
  logic [7:0] vec_cnt, fail_cnt, ff_idx;
  logic [2:0] ff_vec;

  logic       start3;
  logic [2:0] func3;
  logic [2:0] num3;
  logic       busy3, done3, pass3, ffv3;
  logic [2:0] vec_cnt3, fail_cnt3, ff_idx3;
  logic [2:0] ff_vec3;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  snap_t      m;
  logic [2:0] m_func;
  logic [7:0] m_num;
  snap_t      sb[$];

  gate_response_checker_if vif ();
  gate_response_checker_if vif3 ();

  gate_response_checker #(.CNT_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .func             (func),
    .num_vec          (num_vec),
    .vec              (vif),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .vec_cnt          (vec_cnt),
    .fail_cnt         (fail_cnt),
    .first_fail_valid (ffv),
    .first_fail_idx   (ff_idx),
    .first_fail_vec   (ff_vec)
  );

  gate_response_checker #(.CNT_W(3)) dut3 (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start3),
    .func             (func3),
    .num_vec          (num3),
    .vec              (vif3),
    .busy             (busy3),
    .done             (done3),
    .pass             (pass3),
    .vec_cnt          (vec_cnt3),
    .fail_cnt         (fail_cnt3),
    .first_fail_valid (ffv3),
    .first_fail_idx   (ff_idx3),
    .first_fail_vec   (ff_vec3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truth tables indexed by {a, b}.
  function automatic logic ref_out(input logic [2:0] f, input logic ra, input logic rb);
    logic [3:0] tt;
    case (f)
      3'd0:    tt = 4'b0111;
      3'd1:    tt = 4'b1000;
      3'd2:    tt = 4'b1110;
      3'd3:    tt = 4'b0001;
      3'd4:    tt = 4'b0110;
      3'd5:    tt = 4'b1001;
      3'd6:    tt = 4'b0011;
      default: tt = 4'b1100;
    endcase
    return tt[{ra, rb}];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare_top(input string tag);
    snap_t e;
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, ".in_ready"}, 32'(vif.in_ready), 32'(e.rdy));
    check({tag, ".busy"}, 32'(busy), 32'(e.busy));
    check({tag, ".done"}, 32'(done), 32'(e.done));
    check({tag, ".pass"}, 32'(pass), 32'(e.pass));
    check({tag, ".vec_cnt"}, 32'(vec_cnt), 32'(e.vc));
    check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(e.fc));
    check({tag, ".ff_valid"}, 32'(ffv), 32'(e.ffv));
    check({tag, ".ff_idx"}, 32'(ff_idx), 32'(e.idx));
    check({tag, ".ff_vec"}, 32'(ff_vec), 32'(e.fvec));
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic do_start(input string tag, input logic [2:0] f, input logic [7:0] n);
    start   = 1'b1;
    func    = f;
    num_vec = n;
    if (!m.busy) begin
      m_func = f;
      m_num  = n;
      m.vc   = '0;
      m.fc   = '0;
      m.ffv  = 1'b0;
      m.idx  = '0;
      m.fvec = '0;
      m.rdy  = (n != 0);
      m.busy = (n != 0);
      m.done = (n == 0);
      m.pass = (n == 0);
    end
    sb.push_back(m);
    @(negedge clk);
    start = 1'b0;
    compare_top(tag);
  endtask

  task automatic drive(input string tag, input logic va, input logic vb, input logic vc);
    vif.in_valid = 1'b1;
    vif.a        = va;
    vif.b        = vb;
    vif.c        = vc;
    if (m.rdy) begin
      if (vc != ref_out(m_func, va, vb)) begin
        if (m.fc != 8'hff) m.fc = m.fc + 8'd1;
        if (!m.ffv) begin
          m.ffv  = 1'b1;
          m.idx  = m.vc;
          m.fvec = {va, vb, vc};
        end
      end
      m.vc = m.vc + 8'd1;
      if (m.vc == m_num) begin
        m.rdy  = 1'b0;
        m.busy = 1'b0;
        m.done = 1'b1;
        m.pass = (m.fc == 0);
      end
    end
    sb.push_back(m);
    @(negedge clk);
    compare_top(tag);
  endtask

  task automatic idle(input string tag);
    vif.in_valid = 1'b0;
    vif.a        = 1'($urandom_range(1));
    vif.b        = 1'($urandom_range(1));
    vif.c        = 1'($urandom_range(1));
    sb.push_back(m);
    @(negedge clk);
    compare_top(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    func          = '0;
    num_vec       = '0;
    vif.in_valid  = 1'b0;
    vif.a         = 1'b0;
    vif.b         = 1'b0;
    vif.c         = 1'b0;
    start3        = 1'b0;
    func3         = '0;
    num3          = '0;
    vif3.in_valid = 1'b0;
    vif3.a        = 1'b0;
    vif3.b        = 1'b0;
    vif3.c        = 1'b0;
    m             = '0;
    m_func        = '0;
    m_num         = '0;

    repeat (2) @(negedge clk);
    sb.push_back(m);
    compare_top("reset");
    rst_n = 1'b1;
    idle("idle_after_reset");

    // All NAND vectors correct, back-to-back.
    do_start("nand_ok.start", 3'd0, 8'd4);
    drive("nand_ok.v0", 1'b0, 1'b0, 1'b1);
    drive("nand_ok.v1", 1'b0, 1'b1, 1'b1);
    drive("nand_ok.v2", 1'b1, 1'b0, 1'b1);
    drive("nand_ok.v3", 1'b1, 1'b1, 1'b0);
    idle("nand_ok.hold");

    // Single error on the third vector; restart straight from DONE.
    do_start("nand_err.start", 3'd0, 8'd4);
    drive("nand_err.v0", 1'b0, 1'b0, 1'b1);
    drive("nand_err.v1", 1'b0, 1'b1, 1'b1);
    drive("nand_err.v2", 1'b1, 1'b0, 1'b0);
    drive("nand_err.v3", 1'b1, 1'b1, 1'b0);
    idle("nand_err.hold");

    // XOR with gaps, an ignored mid-run start and input after DONE.
    do_start("xor.start", 3'd4, 8'd3);
    drive("xor.v0", 1'b0, 1'b1, 1'b1);
    idle("xor.gap0");
    idle("xor.gap1");
    drive("xor.v1", 1'b1, 1'b1, 1'b0);
    idle("xor.gap2");
    do_start("xor.start_in_run", 3'd1, 8'd5);
    drive("xor.v2", 1'b1, 1'b0, 1'b1);
    drive("xor.after_done0", 1'b1, 1'b1, 1'b1);
    drive("xor.after_done1", 1'b0, 1'b0, 1'b1);
    idle("xor.hold");

    // Zero-length run, then restart with NOT a.
    do_start("zero.start", 3'd2, 8'd0);
    idle("zero.hold");
    do_start("not.start", 3'd6, 8'd2);
    drive("not.v0", 1'b0, 1'b1, 1'b1);
    drive("not.v1", 1'b1, 1'b0, 1'b1);
    idle("not.hold");

    // Reset mid-run: outputs clear without waiting for a clock edge.
    do_start("rst.start", 3'd5, 8'd4);
    drive("rst.v0", 1'b0, 1'b0, 1'b1);
    drive("rst.v1", 1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    m = '0;
    sb.push_back(m);
    compare_top("rst.async");
    vif.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle("rst.idle");
    do_start("rst.buf_start", 3'd7, 8'd1);
    drive("rst.buf_v0", 1'b1, 1'b0, 1'b1);
    idle("rst.buf_hold");

    // Saturation on the 3-bit instance: every NAND vector inverted.
    start3 = 1'b1;
    func3  = 3'd0;
    num3   = 3'd7;
    @(negedge clk);
    start3 = 1'b0;
    check("sat.busy", 32'(busy3), 32'd1);
    for (int i = 0; i < 7; i++) begin
      logic [1:0] ab;
      ab            = 2'(i);
      vif3.in_valid = 1'b1;
      vif3.a        = ab[1];
      vif3.b        = ab[0];
      vif3.c        = ab[1] & ab[0];
      @(negedge clk);
      check($sformatf("sat.fail_cnt%0d", i), 32'(fail_cnt3), 32'(i + 1));
    end
    vif3.in_valid = 1'b0;
    check("sat.vec_cnt", 32'(vec_cnt3), 32'd7);
    check("sat.fail_cnt_max", 32'(fail_cnt3), 32'd7);
    check("sat.done", 32'(done3), 32'd1);
    check("sat.pass", 32'(pass3), 32'd0);
    check("sat.ff_valid", 32'(ffv3), 32'd1);
    check("sat.ff_idx", 32'(ff_idx3), 32'd0);
    check("sat.ff_vec", 32'(ff_vec3), 32'd0);
    @(negedge clk);
    check("sat.in_ready_done", 32'(vif3.in_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
